// File: rtl/jtcop_gfx_arb.sv
// Shares one SDRAM read slot between the three BAC06 tile-ROM ports.
// Each port has a one-word cache; misses are served round-robin, one at a time.
module jtcop_gfx_arb #(
  parameter logic [20:0] B0_OFFSET = 21'h00000,
  parameter logic [20:0] B1_OFFSET = 21'h80000,
  parameter logic [20:0] B2_OFFSET = 21'h100000,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        b0_cs,
  input  logic        b1_cs,
  input  logic        b2_cs,
  input  logic [18:0] b0_addr,
  input  logic [18:0] b1_addr,
  input  logic [18:0] b2_addr,
  output logic [31:0] b0_data,
  output logic [31:0] b1_data,
  output logic [31:0] b2_data,
  output logic        b0_ok,
  output logic        b1_ok,
  output logic        b2_ok,
  output logic        sd_cs,
  output logic [20:0] sd_addr,
  input  logic [31:0] sd_data,
  input  logic        sd_ok,
  output logic        sd_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  localparam logic [20:0] OFFS [3] = '{B0_OFFSET, B1_OFFSET, B2_OFFSET};

  state_t      r_state, w_next;
  logic [18:0] r_cache_addr [3];
  logic [31:0] r_cache_data [3];
  logic [2:0]  r_valid;
  logic [1:0]  r_gnt, r_rr;
  logic [18:0] r_lat_addr;
  logic [7:0]  r_tmo;

  logic [18:0] w_addr [3];
  logic [2:0]  w_cs, w_hit, w_pend;
  logic [1:0]  w_ord [3];
  logic [1:0]  w_sel;
  logic        w_req, w_start, w_done, w_abort;

  assign w_addr = '{b0_addr, b1_addr, b2_addr};
  assign w_cs   = {b2_cs, b1_cs, b0_cs};

  assign w_hit[0] = r_valid[0] && (r_cache_addr[0] == b0_addr);
  assign w_hit[1] = r_valid[1] && (r_cache_addr[1] == b1_addr);
  assign w_hit[2] = r_valid[2] && (r_cache_addr[2] == b2_addr);
  assign w_pend   = w_cs & ~w_hit;

  assign b0_ok   = b0_cs & w_hit[0];
  assign b1_ok   = b1_cs & w_hit[1];
  assign b2_ok   = b2_cs & w_hit[2];
  assign b0_data = r_cache_data[0];
  assign b1_data = r_cache_data[1];
  assign b2_data = r_cache_data[2];

  // Search order starts just after the last granted port.
  always_comb begin
    case (r_rr)
      2'd0:    w_ord = '{2'd1, 2'd2, 2'd0};
      2'd1:    w_ord = '{2'd2, 2'd0, 2'd1};
      default: w_ord = '{2'd0, 2'd1, 2'd2};
    endcase
    w_req = 1'b1;
    w_sel = w_ord[0];
    if (w_pend[w_ord[0]])      w_sel = w_ord[0];
    else if (w_pend[w_ord[1]]) w_sel = w_ord[1];
    else if (w_pend[w_ord[2]]) w_sel = w_ord[2];
    else                       w_req = 1'b0;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_start = 1'b1;
          w_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sd_ok) begin
          w_done = 1'b1;
          w_next = ST_GAP;
        end else if (r_tmo == TIMEOUT) begin
          w_abort = 1'b1;
          w_next  = ST_GAP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_addr <= '{default: '0};
      r_cache_data <= '{default: '0};
      r_valid      <= '0;
      r_gnt        <= 2'd0;
      r_rr         <= 2'd2;
      r_lat_addr   <= '0;
      r_tmo        <= '0;
      sd_cs        <= 1'b0;
      sd_addr      <= '0;
      sd_timeout   <= 1'b0;
    end else begin
      if (w_start) begin
        r_gnt      <= w_sel;
        r_rr       <= w_sel;
        r_lat_addr <= w_addr[w_sel];
        sd_addr    <= {2'b00, w_addr[w_sel]} + OFFS[w_sel];
        sd_cs      <= 1'b1;
        r_tmo      <= '0;
      end
      // The cache takes the latched address, not the port's current one.
      if (w_done) begin
        r_cache_addr[r_gnt] <= r_lat_addr;
        r_cache_data[r_gnt] <= sd_data;
        r_valid[r_gnt]      <= 1'b1;
        sd_cs               <= 1'b0;
      end
      if (w_abort) begin
        sd_cs      <= 1'b0;
        sd_timeout <= 1'b1;
      end
      if (r_state == ST_WAIT && !w_done && !w_abort) r_tmo <= r_tmo + 8'd1;
    end
  end

endmodule

// File: doc/jtcop_gfx_arb.md
Name: jtcop_gfx_arb

Overview:
- Shares one SDRAM read slot between the three BAC06 tile-ROM fetch ports (b0/b1/b2 rom_cs/addr/data/ok) of the video block.
- Each port keeps a one-entry cache of its last fetched 32-bit word, so repeated addresses hit with zero latency.
- Misses go to the SDRAM slot through a round-robin arbiter, one transaction at a time.
- Sits between the video block and the SDRAM controller; each layer's ROM region is relocated by a per-port offset.

Parameters:
- B0_OFFSET, 21'h00000, SDRAM word offset added to b0 addresses
- B1_OFFSET, 21'h80000, SDRAM word offset added to b1 addresses
- B2_OFFSET, 21'h100000, SDRAM word offset added to b2 addresses
- TIMEOUT, 255, maximum WAIT cycles before a transaction is abandoned (8-bit counter)

Ports:
- clk  in  1  system clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- b0_cs / b1_cs / b2_cs  in  1 each  layer fetch request
- b0_addr / b1_addr / b2_addr  in  19 each  layer ROM word address
- b0_data / b1_data / b2_data  out  32 each  cached word for that layer
- b0_ok / b1_ok / b2_ok  out  1 each  cached word valid for the current address
- sd_cs  out  1  SDRAM read request
- sd_addr  out  21  SDRAM word address
- sd_data  in  32  SDRAM read data
- sd_ok  in  1  SDRAM data valid
- sd_timeout  out  1  sticky flag: a transaction was abandoned

Behaviour:
- Reset (async, rst_n=0): all outputs 0; caches invalid; FSM=IDLE; rr_ptr=2 so b0 has first priority; timeout counter 0. Reset mid-transaction drops sd_cs immediately; no cache write.
- Per port n: cache_addr_n[18:0], cache_data_n[31:0], valid_n.
  - hit_n = valid_n & cache_addr_n==bn_addr.
  - bn_ok = bn_cs & hit_n, combinational.
  - bn_data = cache_data_n, registered.
  - pend_n = bn_cs & ~hit_n.
  - Dropping cs does not invalidate the cache.
- FSM states IDLE, WAIT, GAP.
- IDLE:
  - If any pend_n, grant the first pending port in order rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
  - On the next edge: gnt<=n, rr_ptr<=n, lat_addr<=bn_addr, sd_addr<={2'b0,bn_addr}+Bn_OFFSET (mod 2^21), sd_cs<=1, tmo<=0, go to WAIT.
  - If nothing is pending, stay in IDLE with sd_cs=0.
- WAIT:
  - sd_cs held 1; sd_addr stable; tmo increments.
  - On sd_ok=1: cache_addr[gnt]<=lat_addr, cache_data[gnt]<=sd_data, valid[gnt]<=1, sd_cs<=0, go to GAP.
  - Otherwise, when tmo==TIMEOUT: sd_cs<=0, sd_timeout<=1 (sticky until reset), no cache write, go to GAP.
- GAP: one cycle with sd_cs=0 so sd_ok can fall; then go to IDLE. Results are ignored if sd_ok is still high.
- Requester changes addr or drops cs during WAIT:
  - The transaction still completes and the cache is written with lat_addr.
  - The port then misses on its new address and re-arbitrates.
- Latency:
  - Hit: bn_ok in the same cycle the address is presented.
  - Miss with port idle: sd_cs rises 1 cycle after pend_n. If sd_ok arrives k cycles after sd_cs rises, bn_ok rises on the edge after sd_ok.
  - Minimum back-to-back spacing between two grants is 3 cycles (IDLE, WAIT, GAP).
- Simultaneous events:
  - A new request arriving while sd_ok is high waits for the next IDLE.
  - Round-robin guarantees each pending port is granted within 3 transactions.
- Address arithmetic wraps silently at 21 bits.

Test Plan:
- Reset, then b0_cs=1, b0_addr=19'h00010, sd_ok returned 4 cycles after sd_cs with sd_data=32'hDEADBEEF -> sd_addr=21'h00010; b0_ok=1 with b0_data=DEADBEEF one cycle after sd_ok; b0_ok stays 1 with no further sd_cs.
- All three cs rise together (b1_addr=5, b2_addr=7) -> grants in order b0, b1, b2; sd_addr sequence 21'h00000+b0_addr, 21'h80005, 21'h100007; each grant separated by at least one GAP cycle.
- b1 changes from addr 5 to addr 6 mid-WAIT -> cache records addr 5 with data; b1_ok stays 0; a second transaction issues sd_addr=21'h80006.
- sd_ok never asserted -> sd_cs drops after TIMEOUT=255 WAIT cycles; sd_timeout=1 and remains 1; the port is re-requested on the next IDLE.
- rst_n pulsed low during WAIT -> sd_cs=0 and all bn_ok=0 asynchronously; the same address re-fetches after release.
- b2_addr=19'h7FFFF with B2_OFFSET=21'h1F0000 -> sd_addr=21'h06FFFF (wraps mod 2^21).
